// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory sequencer: lane steering, load extension, valid/ready bus handshake.
// Latency: 3 stall cycles minimum, then one DONE cycle; stall holds through any bus wait.
// Backpressure: bus_req_valid stays high until bus_req_ready; optional posted store via DMEM_STORE_BUFFER_EN.
module dmem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic [DATA_W-1:0] rdata,
  output logic              dmem_stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_rdata
);

`ifdef DMEM_STORE_BUFFER_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } ld_meta_t;

  state_t   state;
  ld_meta_t ld_meta;
  logic     posted;

  logic req_any, is_store, post_now;
  assign req_any  = mem_rd | mem_wr;
  assign is_store = mem_wr & ~mem_rd;
  assign post_now = SB_EN & is_store;

  logic [3:0]        strb_c;
  logic [DATA_W-1:0] wdata_c;
  logic [1:0]        off_c;

  always_comb begin
    strb_c  = 4'hF;
    wdata_c = mem_wdata;
    off_c   = 2'b00;
    case (mem_size)
      2'd0: begin
        strb_c  = 4'b0001 << mem_addr[1:0];
        wdata_c = {4{mem_wdata[7:0]}};
        off_c   = mem_addr[1:0];
      end
      2'd1: begin
        strb_c  = 4'b0011 << {mem_addr[1], 1'b0};
        wdata_c = {2{mem_wdata[15:0]}};
        off_c   = {mem_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] shifted, ld_ext;

  always_comb begin
    shifted = bus_resp_rdata >> {ld_meta.off, 3'b000};
    ld_ext  = shifted;
    case (ld_meta.size)
      2'd0:    ld_ext = {{24{~ld_meta.uns & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_ext = {{16{~ld_meta.uns & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // A posted store only holds the pipeline if a new access arrives behind it.
  always_comb begin
    dmem_stall = 1'b0;
    case (state)
      IDLE:       dmem_stall = req_any & ~post_now;
      REQ, RESP:  dmem_stall = posted ? req_any : 1'b1;
      default:    dmem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus_req_valid <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= 4'h0;
      rdata         <= '0;
      ld_meta       <= '0;
      posted        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            state         <= REQ;
            bus_req_valid <= 1'b1;
            bus_req_we    <= is_store;
            bus_req_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
            bus_req_wdata <= wdata_c;
            bus_req_wstrb <= is_store ? strb_c : 4'h0;
            ld_meta       <= '{size: mem_size, uns: mem_unsigned, off: off_c};
            posted        <= post_now;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus_resp_valid) begin
            if (!bus_req_we) rdata <= ld_ext;
            if (posted) begin
              posted <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed-vector bench for dmem_access_unit: table of single accesses plus hand-written
// sequences for bus wait states, reset mid-access and the optional posted store.
module tb_dmem_access_unit;

`ifdef DMEM_STORE_BUFFER_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr, mem_unsigned;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] rdata;
  logic        dmem_stall;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;

  dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .rdata(rdata), .dmem_stall(dmem_stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] resp;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one access and plays an in-order bus slave with the given wait states.
  task automatic run_access(input vec_t v, input int rdy_dly, input int rsp_dly,
                            input bit chk_fields, input bit hold_after,
                            input int exp_stalls, output int vcycles);
    int  rw, pw, cyc, stalls;
    bit  in_resp, resp_sent, posted, fin, seen;
    posted = SB_EN && v.wr && !v.rd;
    @(posedge clk); #1;
    mem_rd = v.rd; mem_wr = v.wr; mem_addr = v.addr; mem_wdata = v.wdata;
    mem_size = v.size; mem_unsigned = v.uns; bus_resp_rdata = v.resp;
    rw = rdy_dly; pw = rsp_dly; in_resp = 0; resp_sent = 0; fin = 0; seen = 0;
    cyc = 0; stalls = 0; vcycles = 0;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (posted && resp_sent) fin = 1;
      else if (!posted && !dmem_stall) begin
        fin = 1;
        if (v.rd || !v.wr) chk("rdata", rdata, v.e_rdata);
      end else if (dmem_stall) stalls++;
      if (!fin) begin
        if (posted && cyc == 1) begin mem_rd = 0; mem_wr = 0; end
        bus_resp_valid = 1'b0;
        if (in_resp) begin
          if (pw == 0) begin bus_resp_valid = 1'b1; in_resp = 0; resp_sent = 1; end
          else pw--;
        end
        if (bus_req_valid) begin
          vcycles++;
          if (chk_fields && !seen) begin
            seen = 1;
            chk("bus_addr", bus_req_addr, v.e_addr);
            chk("bus_we", {31'b0, bus_req_we}, {31'b0, v.e_we});
            chk("bus_wstrb", {28'b0, bus_req_wstrb}, {28'b0, v.e_strb});
            if (v.e_we) chk("bus_wdata", bus_req_wdata, v.e_wdata);
          end
          if (rw == 0) begin bus_req_ready = 1'b1; in_resp = 1; end
          else begin bus_req_ready = 1'b0; rw--; end
        end else bus_req_ready = 1'b0;
      end
    end
    if (!fin) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: access not finished after %0d cycles, expected completion", cyc);
    end
    chk("stall_cycles", stalls, exp_stalls);
    if (!hold_after) begin
      @(posedge clk); #1;
      mem_rd = 0; mem_wr = 0; bus_req_ready = 0; bus_resp_valid = 0;
    end
  endtask

  vec_t tbl [13];
  vec_t v;
  int   vc;

  initial begin
    //         rd    wr    addr       wdata         sz    uns   resp          e_addr     we    strb     e_wdata       e_rdata
    tbl[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 32'h100, 1'b0, 4'b0000, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 32'h103, 32'h0,        2'd0, 1'b0, 32'h80112233, 32'h100, 1'b0, 4'b0000, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1'b1, 1'b0, 32'h103, 32'h0,        2'd0, 1'b1, 32'h80112233, 32'h100, 1'b0, 4'b0000, 32'h0,        32'h00000080};
    tbl[3]  = '{1'b1, 1'b0, 32'h101, 32'h0,        2'd0, 1'b0, 32'h80112233, 32'h100, 1'b0, 4'b0000, 32'h0,        32'h00000022};
    tbl[4]  = '{1'b1, 1'b0, 32'h102, 32'h0,        2'd1, 1'b0, 32'h80112233, 32'h100, 1'b0, 4'b0000, 32'h0,        32'hFFFF8011};
    tbl[5]  = '{1'b1, 1'b0, 32'h103, 32'h0,        2'd1, 1'b1, 32'h80112233, 32'h100, 1'b0, 4'b0000, 32'h0,        32'h00008011};
    tbl[6]  = '{1'b1, 1'b0, 32'h100, 32'h0,        2'd1, 1'b0, 32'h0000F00F, 32'h100, 1'b0, 4'b0000, 32'h0,        32'hFFFFF00F};
    tbl[7]  = '{1'b1, 1'b0, 32'h10B, 32'h0,        2'd3, 1'b0, 32'h01020304, 32'h108, 1'b0, 4'b0000, 32'h0,        32'h01020304};
    tbl[8]  = '{1'b0, 1'b1, 32'h202, 32'h1234,     2'd1, 1'b0, 32'h0,        32'h200, 1'b1, 4'b1100, 32'h12341234, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 32'h201, 32'h123456A5, 2'd0, 1'b0, 32'h0,        32'h200, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 32'h20E, 32'hCAFEBABE, 2'd2, 1'b0, 32'h0,        32'h20C, 1'b1, 4'b1111, 32'hCAFEBABE, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h201, 32'h0000BEEF, 2'd1, 1'b0, 32'h0,        32'h200, 1'b1, 4'b0011, 32'hBEEFBEEF, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 32'h104, 32'h55,       2'd2, 1'b0, 32'h11223344, 32'h104, 1'b0, 4'b0000, 32'h0,        32'h11223344};

    rst = 1; mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0; mem_size = 0;
    mem_unsigned = 0; bus_req_ready = 0; bus_resp_valid = 0; bus_resp_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, bus_req_valid}, 32'h0);
    chk("rst_we", {31'b0, bus_req_we}, 32'h0);
    chk("rst_wstrb", {28'b0, bus_req_wstrb}, 32'h0);
    chk("rst_addr", bus_req_addr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'b0, dmem_stall}, 32'h0);
    @(posedge clk); #1 rst = 0;

    for (int i = 0; i < 13; i++) begin
      v = tbl[i];
      run_access(v, 0, 0, 1'b1, 1'b0, (SB_EN && v.wr && !v.rd) ? 0 : 3, vc);
    end

    // Long bus wait: 5 ready-low cycles, response 2 cycles after acceptance.
    v = tbl[0];
    run_access(v, 5, 2, 1'b1, 1'b1, 10, vc);
    chk("valid_cycles", vc, 6);
    @(negedge clk);
    chk("single_done_recapture", {31'b0, dmem_stall}, 32'h1);

    // Reset while waiting for the response; a late response must be ignored.
    @(negedge clk);
    chk("req_valid_before_rst", {31'b0, bus_req_valid}, 32'h1);
    bus_req_ready = 1;
    @(posedge clk); #1;
    bus_req_ready = 0; rst = 1; mem_rd = 0;
    @(posedge clk); #1;
    rst = 0; bus_resp_valid = 1; bus_resp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_mid_stall", {31'b0, dmem_stall}, 32'h0);
    chk("rst_mid_valid", {31'b0, bus_req_valid}, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    @(posedge clk); #1 bus_resp_valid = 0;
    @(negedge clk);
    chk("late_resp_stall", {31'b0, dmem_stall}, 32'h0);
    chk("late_resp_valid", {31'b0, bus_req_valid}, 32'h0);
    chk("late_resp_rdata", rdata, 32'h0);

`ifdef DMEM_STORE_BUFFER_EN
    // Posted store followed immediately by a load.
    @(posedge clk); #1;
    mem_wr = 1; mem_rd = 0; mem_addr = 32'h300; mem_wdata = 32'h77; mem_size = 2'd2;
    @(negedge clk);
    chk("posted_store_stall", {31'b0, dmem_stall}, 32'h0);
    v = tbl[0];
    v.addr = 32'h104; v.resp = 32'h0BADF00D; v.e_rdata = 32'h0BADF00D;
    run_access(v, 0, 0, 1'b0, 1'b0, 5, vc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
